// File: rtl/mem_pkg.sv
// Shared types for the memory stage: FSM states, datapath widths and the
// EX/MEM pipeline register layout.
package mem_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   wdata;
    logic [REG_AW-1:0] rd;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
  } exmem_t;

  // Word accesses only: the two low address bits must be clear.
  function automatic logic isAligned(input logic [1:0] lowBits);
    return lowBits == 2'b00;
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: loads when enabled, and a bubble (valid=0)
// always enters with every control bit cleared.
module ex_mem_reg
  import mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  exmem_t d,
  output exmem_t q
);

  exmem_t dIns;

  always_comb begin
    dIns = d;
    if (!d.valid) begin
      dIns.mem_read   = 1'b0;
      dIns.mem_write  = 1'b0;
      dIns.reg_write  = 1'b0;
      dIns.mem_to_reg = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated in.
  // It is also reset in full: the forwarding outputs are read straight from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= dIns;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, data-memory handshake FSM with timeout,
// MEM/WB register and the forwarding taps used by the execute stage.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_alu_out,
  input  logic [XLEN-1:0]   ex_mem_wdata,
  input  logic [REG_AW-1:0] ex_reg_dest,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [XLEN-1:0]   dm_addr,
  output logic [XLEN-1:0]   dm_wdata,
  input  logic [XLEN-1:0]   dm_rdata,
  input  logic              dm_ack,
  output logic [XLEN-1:0]   mem_fwd_data,
  output logic [REG_AW-1:0] mem_fwd_rd,
  output logic              mem_fwd_we,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] wb_reg_dest,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state;
  state_e        stateNext;
  logic [CW-1:0] waitCnt;
  exmem_t        exIn;
  exmem_t        exMem;
  logic          advance;
  logic          complete;
  logic          newIsMem;
  logic          newAligned;

  assign exIn = '{valid:      ex_valid,
                  alu_out:    ex_alu_out,
                  wdata:      ex_mem_wdata,
                  rd:         ex_reg_dest,
                  mem_read:   ex_mem_read,
                  mem_write:  ex_mem_write,
                  reg_write:  ex_reg_write,
                  mem_to_reg: ex_mem_to_reg};

  ex_mem_reg u_ex_mem_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (advance),
    .d     (exIn),
    .q     (exMem)
  );

  // In RUN the held entry is never a memory op, so it completes immediately.
  always_comb begin
    // NOTE: defaults before the case so no path leaves a variable unassigned,
    // which would otherwise infer a latch.
    stall    = 1'b0;
    complete = 1'b0;
    case (state)
      RUN:     complete = 1'b1;
      ACCESS: begin
        stall    = !dm_ack;
        complete = dm_ack;
      end
      default: stall = 1'b1;
    endcase
  end

  assign advance    = !stall;
  assign newIsMem   = ex_valid && (ex_mem_read || ex_mem_write);
  assign newAligned = isAligned(ex_alu_out[1:0]);

  // An ack on the last allowed cycle advances, so it beats the timeout.
  always_comb begin
    stateNext = state;
    if (advance) begin
      if (newIsMem) stateNext = newAligned ? ACCESS : ERR;
      else          stateNext = RUN;
    end else if (state == ACCESS && waitCnt == CNT_LAST) begin
      stateNext = ERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      state <= stateNext;
      if (advance)               waitCnt <= '0;
      else if (state == ACCESS)  waitCnt <= waitCnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      wb_reg_dest  <= '0;
    end else if (complete) begin
      wb_valid     <= exMem.valid;
      wb_reg_write <= exMem.valid && exMem.reg_write && !exMem.mem_write;
      wb_data      <= exMem.mem_to_reg ? dm_rdata : exMem.alu_out;
      wb_reg_dest  <= exMem.rd;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
    end
  end

  assign dm_req   = (state == ACCESS);
  assign err      = (state == ERR);
  assign dm_we    = exMem.mem_write;
  assign dm_addr  = exMem.alu_out;
  assign dm_wdata = exMem.wdata;

  assign mem_fwd_data = exMem.alu_out;
  assign mem_fwd_rd   = exMem.rd;
  assign mem_fwd_we   = exMem.valid && exMem.reg_write && !exMem.mem_read;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4): ALU op, waited load, zero-wait
// store, back-to-back loads, misalignment, timeout and reset mid-access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_mem_wdata;
  logic [4:0]  ex_reg_dest;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic [31:0] mem_fwd_data;
  logic [4:0]  mem_fwd_rd;
  logic        mem_fwd_we;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg_dest;
  logic        err;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_alu_out    (ex_alu_out),
    .ex_mem_wdata  (ex_mem_wdata),
    .ex_reg_dest   (ex_reg_dest),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .stall         (stall),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_rdata      (dm_rdata),
    .dm_ack        (dm_ack),
    .mem_fwd_data  (mem_fwd_data),
    .mem_fwd_rd    (mem_fwd_rd),
    .mem_fwd_we    (mem_fwd_we),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .wb_reg_dest   (wb_reg_dest),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setEx(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic mr, input logic mw,
                       input logic rw, input logic m2r);
    ex_valid      = v;
    ex_alu_out    = alu;
    ex_mem_wdata  = wd;
    ex_reg_dest   = rd;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_reg_write  = rw;
    ex_mem_to_reg = m2r;
  endtask

  task automatic setIdle();
    setEx(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    setIdle();

    // Reset values
    step();
    check("rst_stall", stall, 0);
    check("rst_dm_req", dm_req, 0);
    check("rst_err", err, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_fwd_we", mem_fwd_we, 0);
    rst_n = 1'b1;
    step();

    // ALU op: forwarded for one cycle, then in MEM/WB
    setEx(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    setIdle();
    #1;
    check("alu_fwd_data", mem_fwd_data, 32'h0000_1234);
    check("alu_fwd_rd", mem_fwd_rd, 5);
    check("alu_fwd_we", mem_fwd_we, 1);
    check("alu_stall", stall, 0);
    check("alu_dm_req", dm_req, 0);
    step();
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_data", wb_data, 32'h0000_1234);
    check("alu_wb_dest", wb_reg_dest, 5);
    check("alu_wb_rw", wb_reg_write, 1);
    check("alu_fwd_we_gone", mem_fwd_we, 0);

    // Load at 0x100, three wait cycles, ack on the 4th (also the last timeout cycle)
    setEx(1'b1, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    setIdle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ld_stall", stall, 1);
      check("ld_dm_req", dm_req, 1);
      check("ld_addr", dm_addr, 32'h0000_0100);
      check("ld_we", dm_we, 0);
      check("ld_fwd_we", mem_fwd_we, 0);
      step();
      check("ld_wb_bubble", wb_valid, 0);
    end
    dm_ack   = 1'b1;
    dm_rdata = 32'hDEAD_BEEF;
    #1;
    check("ld_ack_stall", stall, 0);
    step();
    dm_ack = 1'b0;
    #1;
    check("ld_wb_valid", wb_valid, 1);
    check("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    check("ld_wb_dest", wb_reg_dest, 7);
    check("ld_wb_rw", wb_reg_write, 1);
    check("ld_err", err, 0);
    check("ld_dm_req_done", dm_req, 0);

    // Zero-wait store: result marks valid but never writes a register
    setEx(1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    setIdle();
    dm_ack = 1'b1;
    #1;
    check("st_dm_req", dm_req, 1);
    check("st_dm_we", dm_we, 1);
    check("st_addr", dm_addr, 32'h0000_0200);
    check("st_wdata", dm_wdata, 32'hA5A5_A5A5);
    check("st_stall", stall, 0);
    step();
    dm_ack = 1'b0;
    #1;
    check("st_wb_valid", wb_valid, 1);
    check("st_wb_rw", wb_reg_write, 0);
    check("st_dm_req_done", dm_req, 0);
    check("st_dm_we_done", dm_we, 0);

    // Back-to-back zero-wait loads
    setEx(1'b1, 32'h0000_0010, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    setEx(1'b1, 32'h0000_0014, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    dm_ack   = 1'b1;
    dm_rdata = 32'h1111_1111;
    #1;
    check("b2b_addr0", dm_addr, 32'h0000_0010);
    check("b2b_stall0", stall, 0);
    step();
    setIdle();
    dm_rdata = 32'h2222_2222;
    #1;
    check("b2b_req1", dm_req, 1);
    check("b2b_addr1", dm_addr, 32'h0000_0014);
    check("b2b_wb0", wb_data, 32'h1111_1111);
    check("b2b_stall1", stall, 0);
    step();
    dm_ack = 1'b0;
    #1;
    check("b2b_wb1", wb_data, 32'h2222_2222);
    check("b2b_wb1_dest", wb_reg_dest, 2);
    check("b2b_req_done", dm_req, 0);

    // Misaligned load: no request, sticky error
    setEx(1'b1, 32'h0000_0102, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    setIdle();
    #1;
    check("mis_err", err, 1);
    check("mis_stall", stall, 1);
    check("mis_dm_req", dm_req, 0);
    dm_ack = 1'b1;
    step();
    step();
    dm_ack = 1'b0;
    #1;
    check("mis_err_sticky", err, 1);
    check("mis_stall_sticky", stall, 1);
    check("mis_wb_bubble", wb_valid, 0);

    // Timeout: four request cycles without an ack
    doReset();
    check("to_rst_err", err, 0);
    setEx(1'b1, 32'h0000_0300, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    setIdle();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to_req", dm_req, 1);
      check("to_no_err", err, 0);
      step();
    end
    check("to_err", err, 1);
    check("to_stall", stall, 1);
    check("to_dm_req", dm_req, 0);

    // Reset asserted mid-load, late ack ignored, then normal operation
    doReset();
    setEx(1'b1, 32'h0000_0400, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    setIdle();
    #1;
    check("rml_req", dm_req, 1);
    rst_n = 1'b0;
    #1;
    check("rml_req_drop", dm_req, 0);
    check("rml_addr", dm_addr, 0);
    check("rml_stall", stall, 0);
    check("rml_fwd_data", mem_fwd_data, 0);
    check("rml_wb_valid", wb_valid, 0);
    step();
    rst_n    = 1'b1;
    dm_ack   = 1'b1;
    dm_rdata = 32'hBAD0_BAD0;
    step();
    dm_ack = 1'b0;
    #1;
    check("rml_late_ack_wb", wb_valid, 0);
    check("rml_late_ack_req", dm_req, 0);
    check("rml_late_ack_err", err, 0);
    setEx(1'b1, 32'h0000_0055, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    setIdle();
    step();
    check("rml_new_wb_valid", wb_valid, 1);
    check("rml_new_wb_data", wb_data, 32'h0000_0055);
    check("rml_new_wb_dest", wb_reg_dest, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
